// File: rtl/adf4351_pkg.sv
// Shared ADF4351 lock-monitor definitions: state encoding, counter widths and
// default timing constants, also used by the PLL programmer.
package adf4351_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned LOST_CNT_W = 8;

  // Defaults assume a 50 MHz clk_50.
  localparam int unsigned DEF_SYNC_STAGES      = 2;
  localparam int unsigned DEF_DEBOUNCE_CYC     = 5000;    // 100 us
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 500000;  // 10 ms
  localparam int unsigned DEF_MAX_RETRY        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_LOCKED    = 3'd2,
    ST_RELOCK    = 3'd3,
    ST_FAULT     = 3'd4
  } lock_state_e;

  // One spare bit over $clog2 so a counter can hold its limit without wrapping.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/adf4351_lock_mon_ld_debounce.sv
// Synchroniser plus debouncer for the asynchronous ADF4351 lock-detect pin.
module ld_debounce
  import adf4351_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic vco_ld,
  output logic ld_deb
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ld_deb_q, ld_deb_d;
  logic                   ld_sync;

  assign ld_sync = sync_q[SYNC_STAGES-1];
  assign ld_deb  = ld_deb_q;

  // Accept a new level only after it has disagreed with ld_deb for
  // DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], vco_ld};
    ld_deb_d = ld_deb_q;
    cnt_d    = '0;
    if (ld_sync != ld_deb_q) begin
      if (cnt_q == CNT_LAST) begin
        ld_deb_d = ld_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      ld_deb_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      ld_deb_q <= ld_deb_d;
    end
  end

endmodule

// File: rtl/adf4351_lock_mon.sv
// ADF4351 lock monitor: debounced lock tracking, lock timeout, relock handshake
// and fault latch. ADF4351_AUTO_RELOCK_EN enables automatic relock requests.
module adf4351_lock_mon
  import adf4351_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic                  clk_50,
  input  logic                  rst_n,
  input  logic                  vco_ld,
  input  logic                  cfg_done,
  input  logic                  relock_ack,
  input  logic                  err_clr,
  output logic                  relock_req,
  output logic                  pll_locked,
  output logic                  lock_err,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt,
  output logic [STATE_W-1:0]    state_o
);

  localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYC - 1);

  lock_state_e           state_q, state_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [LOST_CNT_W-1:0] lost_q, lost_d;
  logic                  pll_locked_q, pll_locked_d;
  logic                  lock_err_q, lock_err_d;
  logic                  ld_deb;
  logic                  timeout;
  logic                  loss;

`ifdef ADF4351_AUTO_RELOCK_EN
  localparam int unsigned RETRY_W = cnt_width(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               relock_req_q, relock_req_d;

  assign relock_req = relock_req_q;
`else
  logic unused_cfg;

  assign relock_req = 1'b0;
  assign unused_cfg = relock_ack | (MAX_RETRY == 32'd0);
`endif

  ld_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_ld_debounce (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .vco_ld (vco_ld),
    .ld_deb (ld_deb)
  );

  assign pll_locked    = pll_locked_q;
  assign lock_err      = lock_err_q;
  assign lock_lost_cnt = lost_q;
  assign state_o       = state_q;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    lost_d  = lost_q;
    timeout = 1'b0;
    loss    = 1'b0;
`ifdef ADF4351_AUTO_RELOCK_EN
    retry_d = retry_q;
`endif
    // A fresh register sequence outranks a loss or timeout in the same cycle.
    if (cfg_done && (state_q != ST_FAULT)) begin
      state_d = ST_WAIT_LOCK;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (ld_deb) begin
            state_d = ST_LOCKED;
`ifdef ADF4351_AUTO_RELOCK_EN
            retry_d = '0;
`endif
          end else if (tmo_q == TMO_LAST) begin
            timeout = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!ld_deb) begin
            loss = 1'b1;
            if (lost_q != '1) begin
              lost_d = lost_q + LOST_CNT_W'(1);
            end
          end
        end
`ifdef ADF4351_AUTO_RELOCK_EN
        ST_RELOCK: begin
          if (relock_ack) begin
            state_d = ST_IDLE;
          end
        end
`endif
        ST_FAULT: begin
          if (err_clr) begin
            state_d = ST_IDLE;
`ifdef ADF4351_AUTO_RELOCK_EN
            retry_d = '0;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase

`ifdef ADF4351_AUTO_RELOCK_EN
      if (timeout || loss) begin
        if (retry_q == RETRY_MAX) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RELOCK;
          retry_d = retry_q + RETRY_W'(1);
        end
      end
`else
      if (timeout) begin
        state_d = ST_FAULT;
      end
      if (loss) begin
        state_d = ST_WAIT_LOCK;
        tmo_d   = '0;
      end
`endif
    end

    pll_locked_d = (state_d == ST_LOCKED);
    lock_err_d   = (state_d == ST_FAULT);
`ifdef ADF4351_AUTO_RELOCK_EN
    relock_req_d = (state_d == ST_RELOCK);
`endif
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      lost_q       <= '0;
      pll_locked_q <= 1'b0;
      lock_err_q   <= 1'b0;
`ifdef ADF4351_AUTO_RELOCK_EN
      retry_q      <= '0;
      relock_req_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      lost_q       <= lost_d;
      pll_locked_q <= pll_locked_d;
      lock_err_q   <= lock_err_d;
`ifdef ADF4351_AUTO_RELOCK_EN
      retry_q      <= retry_d;
      relock_req_q <= relock_req_d;
`endif
    end
  end

endmodule

// File: tb/tb_adf4351_lock_mon.sv
// Self-checking bench for adf4351_lock_mon: directed table, corner sequences
// and randomized traffic against a behavioural model (either macro setting).
module tb_adf4351_lock_mon;
  import adf4351_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int TMO  = 20;
  localparam int MAXR = 2;
`ifdef ADF4351_AUTO_RELOCK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam lock_state_e LOSS_ST = AUTO ? ST_RELOCK : ST_WAIT_LOCK;
  localparam lock_state_e ACK_ST  = AUTO ? ST_IDLE : ST_WAIT_LOCK;

  logic       clk_50 = 1'b0;
  logic       rst_n, vco_ld, cfg_done, relock_ack, err_clr;
  logic       relock_req, pll_locked, lock_err;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  bit saw_req;

  adf4351_lock_mon #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYC     (DEB),
    .LOCK_TIMEOUT_CYC (TMO),
    .MAX_RETRY        (MAXR)
  ) dut (
    .clk_50        (clk_50),
    .rst_n         (rst_n),
    .vco_ld        (vco_ld),
    .cfg_done      (cfg_done),
    .relock_ack    (relock_ack),
    .err_clr       (err_clr),
    .relock_req    (relock_req),
    .pll_locked    (pll_locked),
    .lock_err      (lock_err),
    .lock_lost_cnt (lock_lost_cnt),
    .state_o       (state_o)
  );

  always #10 clk_50 = ~clk_50;

  // ---------------- behavioural reference model ----------------
  bit          m_line[$];   // raw pin samples still inside the synchroniser
  bit          m_deb = 1'b0;
  int          m_run = 0;   // consecutive cycles the synchronised pin disagreed
  lock_state_e m_st = ST_IDLE;
  int          m_waited = 0;
  int          m_relocks = 0;
  int          m_lost = 0;

  task automatic model_fail(input bit is_timeout, inout lock_state_e nxt);
    if (AUTO) begin
      if (m_relocks == MAXR) nxt = ST_FAULT;
      else begin
        nxt = ST_RELOCK;
        m_relocks++;
      end
    end else if (is_timeout) begin
      nxt = ST_FAULT;
    end else begin
      nxt = ST_WAIT_LOCK;
      m_waited = 0;
    end
  endtask

  task automatic model_step();
    bit sync_now, deb_now;
    lock_state_e nxt;
    if (!rst_n) begin
      m_line = {};
      for (int i = 0; i < SYNC; i++) m_line.push_back(1'b0);
      m_deb = 1'b0; m_run = 0; m_st = ST_IDLE;
      m_waited = 0; m_relocks = 0; m_lost = 0;
      return;
    end
    deb_now  = m_deb;
    sync_now = m_line[0];
    m_line.push_back(vco_ld);
    void'(m_line.pop_front());
    if (sync_now != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = sync_now;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end

    nxt = m_st;
    if (cfg_done && m_st != ST_FAULT) begin
      nxt = ST_WAIT_LOCK;
      m_waited = 0;
    end else begin
      case (m_st)
        ST_WAIT_LOCK: begin
          if (deb_now) begin
            nxt = ST_LOCKED;
            m_relocks = 0;
          end else begin
            m_waited++;
            if (m_waited == TMO) model_fail(1'b1, nxt);
          end
        end
        ST_LOCKED: begin
          if (!deb_now) begin
            m_lost = (m_lost < 255) ? m_lost + 1 : 255;
            model_fail(1'b0, nxt);
          end
        end
        ST_RELOCK: if (relock_ack) nxt = ST_IDLE;
        ST_FAULT: begin
          if (err_clr) begin
            nxt = ST_IDLE;
            m_relocks = 0;
          end
        end
        default: nxt = ST_IDLE;
      endcase
    end
    m_st = nxt;
  endtask

  task automatic check_model();
    checks++;
    if (state_o !== m_st || pll_locked !== (m_st == ST_LOCKED) ||
        relock_req !== (m_st == ST_RELOCK) || lock_err !== (m_st == ST_FAULT) ||
        lock_lost_cnt !== 8'(m_lost)) begin
      errors++;
      $display("FAIL model t=%0t got st=%0d lk=%0b rq=%0b er=%0b lost=%0d want st=%0d lost=%0d",
               $time, state_o, pll_locked, relock_req, lock_err, lock_lost_cnt, m_st, m_lost);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    model_step();
    @(negedge clk_50);
    check_model();
    if (relock_req === 1'b1) saw_req = 1'b1;
  endtask

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vco_ld = 1'b0; cfg_done = 1'b0; relock_ack = 1'b0; err_clr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_cfg();
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit r, v, c, a, e;
    int n;
    lock_state_e st;
    bit lk, rq, er;
    int lost;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, v, c, a, e, input int n, input lock_state_e st,
                     input bit lk, rq, er, input int lost);
    vec_t x;
    x.r = r; x.v = v; x.c = c; x.a = a; x.e = e; x.n = n;
    x.st = st; x.lk = lk; x.rq = rq; x.er = er; x.lost = lost;
    tbl.push_back(x);
  endtask

  initial begin
    int run_left;
    rst_n = 1'b0; vco_ld = 1'b0; cfg_done = 1'b0; relock_ack = 1'b0; err_clr = 1'b0;
    saw_req = 1'b0;

    //  rst vco cfg ack clr cyc  state         lk rq    er lost
    add(0, 0, 0, 0, 0, 3, ST_IDLE,      0, 0,    0, 0);
    add(1, 0, 0, 0, 0, 2, ST_IDLE,      0, 0,    0, 0);
    add(1, 0, 1, 0, 0, 1, ST_WAIT_LOCK, 0, 0,    0, 0);
    add(1, 1, 0, 0, 0, 6, ST_WAIT_LOCK, 0, 0,    0, 0);
    add(1, 1, 0, 0, 0, 1, ST_LOCKED,    1, 0,    0, 0);
    add(1, 0, 0, 0, 0, 2, ST_LOCKED,    1, 0,    0, 0);
    add(1, 1, 0, 0, 0, 8, ST_LOCKED,    1, 0,    0, 0);
    add(1, 0, 0, 0, 0, 6, ST_LOCKED,    1, 0,    0, 0);
    add(1, 0, 0, 0, 0, 1, LOSS_ST,      0, AUTO, 0, 1);
    add(1, 0, 0, 0, 0, 3, LOSS_ST,      0, AUTO, 0, 1);
    add(1, 0, 0, 1, 0, 1, ACK_ST,       0, 0,    0, 1);
    add(1, 0, 0, 0, 0, 1, ACK_ST,       0, 0,    0, 1);
    add(1, 1, 1, 0, 0, 1, ST_WAIT_LOCK, 0, 0,    0, 1);
    add(1, 1, 0, 0, 0, 5, ST_WAIT_LOCK, 0, 0,    0, 1);
    add(1, 1, 0, 0, 0, 1, ST_LOCKED,    1, 0,    0, 1);
    add(1, 1, 1, 0, 0, 1, ST_WAIT_LOCK, 0, 0,    0, 1);
    add(1, 1, 0, 0, 0, 1, ST_LOCKED,    1, 0,    0, 1);

    foreach (tbl[i]) begin
      rst_n = tbl[i].r; vco_ld = tbl[i].v; cfg_done = tbl[i].c;
      relock_ack = tbl[i].a; err_clr = tbl[i].e;
      repeat (tbl[i].n) tick();
      checks++;
      if (state_o !== tbl[i].st || pll_locked !== tbl[i].lk || relock_req !== tbl[i].rq ||
          lock_err !== tbl[i].er || lock_lost_cnt !== 8'(tbl[i].lost)) begin
        errors++;
        $display("FAIL vec[%0d] got st=%0d lk=%0b rq=%0b er=%0b lost=%0d want st=%0d lk=%0b rq=%0b er=%0b lost=%0d",
                 i, state_o, pll_locked, relock_req, lock_err, lock_lost_cnt,
                 tbl[i].st, tbl[i].lk, tbl[i].rq, tbl[i].er, tbl[i].lost);
      end
    end

    // Repeated timeouts: retries exhaust into FAULT, err_clr recovers.
    do_reset();
    saw_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_cfg();
      repeat (TMO - 1) tick();
      check_eq("tmo_pre_state", state_o, (AUTO || i == 0) ? ST_WAIT_LOCK : ST_FAULT);
      tick();
      check_eq("tmo_state", state_o, (AUTO && i < MAXR) ? ST_RELOCK : ST_FAULT);
      check_eq("tmo_req", relock_req, AUTO && i < MAXR);
      if (relock_req === 1'b1) begin
        relock_ack = 1'b1;
        tick();
        relock_ack = 1'b0;
      end
      check_eq("tmo_after_ack", state_o, (AUTO && i < MAXR) ? ST_IDLE : ST_FAULT);
    end
    check_eq("fault_err", lock_err, 1);
    check_eq("req_seen", saw_req, AUTO);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("clr_state", state_o, ST_IDLE);
    check_eq("clr_err", lock_err, 0);

    // Reset in the middle of a relock handshake.
    do_reset();
    pulse_cfg();
    repeat (TMO) tick();
    check_eq("mid_req", relock_req, AUTO);
    rst_n = 1'b0;
    tick();
    check_eq("rst_state", state_o, ST_IDLE);
    check_eq("rst_outs", {relock_req, pll_locked, lock_err}, 0);
    check_eq("rst_lost", lock_lost_cnt, 0);
    rst_n = 1'b1;

    // cfg_done colliding with a timeout wins and leaves the retry count alone.
    do_reset();
    pulse_cfg();
    repeat (TMO) tick();
    if (relock_req === 1'b1) begin relock_ack = 1'b1; tick(); relock_ack = 1'b0; end
    if (lock_err === 1'b1) begin err_clr = 1'b1; tick(); err_clr = 1'b0; end
    check_eq("col_idle", state_o, ST_IDLE);
    pulse_cfg();
    repeat (TMO - 1) tick();
    check_eq("col_pre", state_o, ST_WAIT_LOCK);
    pulse_cfg();
    check_eq("col_win", state_o, ST_WAIT_LOCK);
    repeat (TMO - 1) tick();
    check_eq("col_cleared", state_o, ST_WAIT_LOCK);
    tick();
    check_eq("col_timeout", state_o, AUTO ? ST_RELOCK : ST_FAULT);
    if (relock_req === 1'b1) begin relock_ack = 1'b1; tick(); relock_ack = 1'b0; end
    pulse_cfg();
    repeat (TMO) tick();
    check_eq("col_exhaust", state_o, ST_FAULT);

    // Loss counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      pulse_cfg();
      vco_ld = 1'b1;
      repeat (8) tick();
      vco_ld = 1'b0;
      repeat (8) tick();
      relock_ack = 1'b1;
      tick();
      relock_ack = 1'b0;
      if (i == 9) check_eq("lost_10", lock_lost_cnt, 10);
    end
    check_eq("lost_sat", lock_lost_cnt, 255);

    // Randomized traffic against the model.
    do_reset();
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        vco_ld = ~vco_ld;
        run_left = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 40))
                                               : int'($urandom_range(1, 12));
      end
      run_left--;
      cfg_done   = ($urandom_range(0, 39) == 0);
      relock_ack = ($urandom_range(0, 3) == 0);
      err_clr    = ($urandom_range(0, 19) == 0);
      rst_n      = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
